// File: rtl/system86_pkg.sv
// Shared System 86 video definitions: default widths, CUS43 register offsets,
// layer select and the 2bpp tile pixel decode.
package system86_pkg;

    localparam int unsigned DOT_W_DEF = 8;
    localparam int unsigned PRI_W_DEF = 3;

    localparam logic [1:0] REG_FINE = 2'b01;
    localparam logic [1:0] REG_PRI  = 2'b10;

    typedef enum logic {
        LAYER_A = 1'b0,
        LAYER_B = 1'b1
    } layer_e;

    // Pixel i (0 = leftmost) of a 4-pixel group; plane 1 in gd[7:4], plane 0 in gd[3:0].
    function automatic logic [1:0] decode_pix(input logic [7:0] gd, input logic flip,
                                              input logic [1:0] i);
        logic [2:0] lo;
        lo = flip ? {1'b0, i} : 3'd3 - {1'b0, i};
        return {gd[lo + 3'd4], gd[lo]};
    endfunction

endpackage

// File: rtl/cus43_layer.sv
// One CUS43 tile layer: holding latch, 2-group pixel window, fine scroll and
// priority registers, and selection of the current pixel.
module cus43_layer
    import system86_pkg::*;
#(
    parameter int unsigned DOT_W = DOT_W_DEF,
    parameter int unsigned PRI_W = PRI_W_DEF
) (
    input  logic             CLK_6M,
    input  logic             rst_n,
    input  logic             nHSYNC,
    input  logic             capture,
    input  logic             shift,
    input  logic             flip,
    input  logic [1:0]       px,
    input  logic [5:0]       attr,
    input  logic [7:0]       gd,
    input  logic             fine_we,
    input  logic [1:0]       fine_wdata,
    input  logic             pri_we,
    input  logic [PRI_W-1:0] pri_wdata,
    output logic [DOT_W-1:0] dot,
    output logic             opaque,
    output logic [PRI_W-1:0] pri
);

    logic [5:0]      hold_attr_q, new_attr_q, old_attr_q;
    logic [3:0][1:0] hold_pix_q, new_pix_q, old_pix_q, cap_pix;
    logic [1:0]      fine_q;
    logic [PRI_W-1:0] pri_q;
    logic [2:0]      idx;
    logic [5:0]      sel_attr;
    logic [1:0]      sel_pix;

    // Decode at capture so a later FLIP change leaves latched groups alone.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cap_pix[i] = decode_pix(gd, flip, 2'(i));
        end
    end

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            hold_attr_q <= '0;
            hold_pix_q  <= '0;
            new_attr_q  <= '0;
            new_pix_q   <= '0;
            old_attr_q  <= '0;
            old_pix_q   <= '0;
        end else if (!nHSYNC) begin
            hold_attr_q <= '0;
            hold_pix_q  <= '0;
            new_attr_q  <= '0;
            new_pix_q   <= '0;
            old_attr_q  <= '0;
            old_pix_q   <= '0;
        end else begin
            if (capture) begin
                hold_attr_q <= attr;
                hold_pix_q  <= cap_pix;
            end
            if (shift) begin
                old_attr_q <= new_attr_q;
                old_pix_q  <= new_pix_q;
                new_attr_q <= hold_attr_q;
                new_pix_q  <= hold_pix_q;
            end
        end
    end

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            fine_q <= '0;
            pri_q  <= '0;
        end else begin
            if (fine_we) fine_q <= fine_wdata;
            if (pri_we)  pri_q  <= pri_wdata;
        end
    end

    // Window index 0-3 is the older group, 4-6 the newer one.
    always_comb begin
        idx = {1'b0, px} + {1'b0, fine_q};
        if (idx[2]) begin
            sel_attr = new_attr_q;
            sel_pix  = new_pix_q[idx[1:0]];
        end else begin
            sel_attr = old_attr_q;
            sel_pix  = old_pix_q[idx[1:0]];
        end
    end

    assign dot    = DOT_W'({sel_attr, sel_pix});
    assign opaque = (sel_pix != 2'b00);
    assign pri    = pri_q;

endmodule

// File: rtl/cus43.sv
// CUS43 two-layer tile mixer: group phase, CPU register decode, layer priority
// mix against the upstream pixel. Optional fine scroll: CUS43_FINE_SCROLL_EN.
module cus43
    import system86_pkg::*;
#(
    parameter int unsigned DOT_W = DOT_W_DEF,
    parameter int unsigned PRI_W = PRI_W_DEF
) (
    input  logic             CLK_6M,
    input  logic             rst_n,
    input  logic             nHSYNC,
    input  logic             CLK_2H,
    input  logic             FLIP,
    input  logic             nLATCH,
    input  logic [2:0]       CA,
    input  logic [7:0]       CD,
    input  logic [7:0]       RD,
    input  logic [7:0]       GD,
    input  logic [DOT_W-1:0] DOT_IN,
    input  logic [PRI_W-1:0] PRI_IN,
    output logic [DOT_W-1:0] DOT_OUT,
    output logic [PRI_W-1:0] PRI_OUT
);

    logic [1:0]       px_q;
    logic             shift, cap_a, cap_b;
    logic             wr_fine, wr_pri;
    layer_e           wr_layer;
    logic [DOT_W-1:0] dot_a, dot_b, cand_dot, dot_d;
    logic [PRI_W-1:0] pri_a, pri_b, cand_pri, pri_d;
    logic             opq_a, opq_b, cand_valid;
    logic             unused_bits;

    assign unused_bits = ^{CD[7:PRI_W], RD[7:6]};

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= '0;
        end else if (!nHSYNC) begin
            px_q <= '0;
        end else begin
            px_q <= px_q + 2'd1;
        end
    end

    assign shift = (px_q == 2'd3);
    assign cap_a = !CLK_2H && (px_q == 2'd1);
    assign cap_b = CLK_2H && (px_q == 2'd3);

    assign wr_layer = layer_e'(CA[2]);
    assign wr_pri   = !nLATCH && (CA[1:0] == REG_PRI);
`ifdef CUS43_FINE_SCROLL_EN
    assign wr_fine  = !nLATCH && (CA[1:0] == REG_FINE);
`else
    assign wr_fine  = 1'b0;
`endif

    cus43_layer #(.DOT_W(DOT_W), .PRI_W(PRI_W)) u_layer_a (
        .CLK_6M     (CLK_6M),
        .rst_n      (rst_n),
        .nHSYNC     (nHSYNC),
        .capture    (cap_a),
        .shift      (shift),
        .flip       (FLIP),
        .px         (px_q),
        .attr       (RD[5:0]),
        .gd         (GD),
        .fine_we    (wr_fine && (wr_layer == LAYER_A)),
        .fine_wdata (CD[1:0]),
        .pri_we     (wr_pri && (wr_layer == LAYER_A)),
        .pri_wdata  (CD[PRI_W-1:0]),
        .dot        (dot_a),
        .opaque     (opq_a),
        .pri        (pri_a)
    );

    cus43_layer #(.DOT_W(DOT_W), .PRI_W(PRI_W)) u_layer_b (
        .CLK_6M     (CLK_6M),
        .rst_n      (rst_n),
        .nHSYNC     (nHSYNC),
        .capture    (cap_b),
        .shift      (shift),
        .flip       (FLIP),
        .px         (px_q),
        .attr       (RD[5:0]),
        .gd         (GD),
        .fine_we    (wr_fine && (wr_layer == LAYER_B)),
        .fine_wdata (CD[1:0]),
        .pri_we     (wr_pri && (wr_layer == LAYER_B)),
        .pri_wdata  (CD[PRI_W-1:0]),
        .dot        (dot_b),
        .opaque     (opq_b),
        .pri        (pri_b)
    );

    // Layer A wins layer ties; upstream wins ties against the chosen layer.
    always_comb begin
        cand_valid = 1'b0;
        cand_dot   = dot_a;
        cand_pri   = pri_a;
        if (opq_a && (!opq_b || (pri_a >= pri_b))) begin
            cand_valid = 1'b1;
        end else if (opq_b) begin
            cand_valid = 1'b1;
            cand_dot   = dot_b;
            cand_pri   = pri_b;
        end
        if (cand_valid && (cand_pri > PRI_IN)) begin
            dot_d = cand_dot;
            pri_d = cand_pri;
        end else begin
            dot_d = DOT_IN;
            pri_d = PRI_IN;
        end
    end

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            DOT_OUT <= '0;
            PRI_OUT <= '0;
        end else begin
            DOT_OUT <= dot_d;
            PRI_OUT <= pri_d;
        end
    end

endmodule

// File: tb/tb_cus43.sv
// Self-checking bench for cus43: directed scenario table plus randomized
// traffic against a behavioural pixel-strip model.
module tb_cus43;

    logic       clk;
    logic       rst_n;
    logic       nhsync, clk_2h, flip, nlatch;
    logic [2:0] ca;
    logic [7:0] cd, rd, gd, dot_in, dot_out;
    logic [2:0] pri_in, pri_out;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    cus43 dut (
        .CLK_6M  (clk),
        .rst_n   (rst_n),
        .nHSYNC  (nhsync),
        .CLK_2H  (clk_2h),
        .FLIP    (flip),
        .nLATCH  (nlatch),
        .CA      (ca),
        .CD      (cd),
        .RD      (rd),
        .GD      (gd),
        .DOT_IN  (dot_in),
        .PRI_IN  (pri_in),
        .DOT_OUT (dot_out),
        .PRI_OUT (pri_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each layer is a strip of 8 finished colours (older group then newer
    // group) plus a 4-colour holding group; colour low bits 00 means transparent.
    int unsigned m_px;
    logic [7:0]  m_win  [2][8];
    logic [7:0]  m_hold [2][4];
    logic [1:0]  m_fine [2];
    logic [2:0]  m_pri  [2];
    logic [7:0]  exp_dot;
    logic [2:0]  exp_pri;

    function automatic logic [1:0] ref_pix(input logic [7:0] g, input logic f, input int i);
        return f ? {g[4+i], g[i]} : {g[7-i], g[3-i]};
    endfunction

    function automatic int fine_eff(input int l);
`ifdef CUS43_FINE_SCROLL_EN
        return int'(m_fine[l]);
`else
        return 0 * l;
`endif
    endfunction

    task automatic model_clear_win();
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 8; i++) m_win[l][i] = 8'h00;
            for (int i = 0; i < 4; i++) m_hold[l][i] = 8'h00;
        end
    endtask

    task automatic model_clear();
        model_clear_win();
        m_px = 0;
        for (int l = 0; l < 2; l++) begin
            m_fine[l] = 2'd0;
            m_pri[l]  = 3'd0;
        end
    endtask

    task automatic model_step();
        logic [7:0] c [2];
        bit         op [2];
        int         sel;
        if (!rst_n) begin
            model_clear();
            exp_dot = 8'h00;
            exp_pri = 3'd0;
            return;
        end
        for (int l = 0; l < 2; l++) begin
            c[l]  = m_win[l][m_px + fine_eff(l)];
            op[l] = (c[l][1:0] != 2'b00);
        end
        sel = -1;
        if (op[0] && (!op[1] || m_pri[0] >= m_pri[1])) sel = 0;
        else if (op[1]) sel = 1;
        if (sel >= 0 && m_pri[sel] > pri_in) begin
            exp_dot = c[sel];
            exp_pri = m_pri[sel];
        end else begin
            exp_dot = dot_in;
            exp_pri = pri_in;
        end
        if (!nlatch) begin
            if (ca[1:0] == 2'b10) m_pri[int'(ca[2])]  = cd[2:0];
            if (ca[1:0] == 2'b01) m_fine[int'(ca[2])] = cd[1:0];
        end
        if (!nhsync) begin
            model_clear_win();
            m_px = 0;
            return;
        end
        if (m_px == 3) begin
            for (int l = 0; l < 2; l++) begin
                for (int i = 0; i < 4; i++) begin
                    m_win[l][i]   = m_win[l][i+4];
                    m_win[l][i+4] = m_hold[l][i];
                end
            end
        end
        if (!clk_2h && m_px == 1)
            for (int i = 0; i < 4; i++) m_hold[0][i] = {rd[5:0], ref_pix(gd, flip, i)};
        if (clk_2h && m_px == 3)
            for (int i = 0; i < 4; i++) m_hold[1][i] = {rd[5:0], ref_pix(gd, flip, i)};
        m_px = (m_px + 1) % 4;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] want_dot, input logic [2:0] want_pri);
        n_vec++;
        if (dot_out !== want_dot || pri_out !== want_pri) begin
            n_bad++;
            $display("FAIL %s: got dot=%h pri=%0d, want dot=%h pri=%0d",
                     name, dot_out, pri_out, want_dot, want_pri);
        end
    endtask

    typedef struct {
        logic [7:0]  rd_a, gd_a, rd_b, gd_b;
        logic        flip;
        logic [1:0]  fine;
        logic [2:0]  pri_a, pri_b, pri_in;
        int unsigned mask;
        logic [7:0]  hit_dot;
        logic [2:0]  hit_pri;
    } scen_t;

    scen_t scen [7];

`ifdef CUS43_FINE_SCROLL_EN
    localparam int unsigned Fine2Mask = 32'h3C00;
`else
    localparam int unsigned Fine2Mask = 32'hF000;
`endif

    // Hblank register setup, then rows with A captured at row 5 and B at row 3.
    task automatic run_scen(input scen_t s, input int nrows, input string name);
        nhsync = 1'b0; nlatch = 1'b0;
        ca = 3'b010; cd = {5'd0, s.pri_a}; tick();
        ca = 3'b110; cd = {5'd0, s.pri_b}; tick();
        ca = 3'b001; cd = {6'd0, s.fine};  tick();
        nlatch = 1'b1; ca = 3'b000; cd = 8'h00; tick();
        nhsync = 1'b1;
        for (int r = 0; r < nrows; r++) begin
            clk_2h = ((r % 4) >= 2);
            if (r == 5) begin
                rd = s.rd_a; gd = s.gd_a; flip = s.flip;
            end else if (r == 3) begin
                rd = s.rd_b; gd = s.gd_b; flip = s.flip;
            end else begin
                rd = 8'h00; gd = 8'h00; flip = ~s.flip;
            end
            dot_in = 8'h40 + 8'(r);
            pri_in = s.pri_in;
            tick();
            if (s.mask[r]) check($sformatf("%s row%0d", name, r), s.hit_dot, s.hit_pri);
            else           check($sformatf("%s row%0d", name, r), dot_in, pri_in);
        end
    endtask

    initial begin
        scen[0] = '{8'h03, 8'hF0, 8'h00, 8'h00, 1'b0, 2'd0, 3'd5, 3'd0, 3'd2, 32'hF000, 8'h0E, 3'd5};
        scen[1] = '{8'h03, 8'hF0, 8'h00, 8'h00, 1'b0, 2'd2, 3'd5, 3'd0, 3'd2, Fine2Mask, 8'h0E, 3'd5};
        scen[2] = '{8'h03, 8'h80, 8'h00, 8'h00, 1'b0, 2'd0, 3'd5, 3'd0, 3'd2, 32'h1000, 8'h0E, 3'd5};
        scen[3] = '{8'h03, 8'h80, 8'h00, 8'h00, 1'b1, 2'd0, 3'd5, 3'd0, 3'd2, 32'h8000, 8'h0E, 3'd5};
        scen[4] = '{8'h03, 8'hF0, 8'h07, 8'hF0, 1'b0, 2'd0, 3'd4, 3'd4, 3'd3, 32'hF000, 8'h0E, 3'd4};
        scen[5] = '{8'h03, 8'hF0, 8'h07, 8'hF0, 1'b0, 2'd0, 3'd4, 3'd4, 3'd4, 32'h0000, 8'h0E, 3'd4};
        scen[6] = '{8'h03, 8'hF0, 8'h07, 8'hF0, 1'b0, 2'd0, 3'd3, 3'd4, 3'd2, 32'hF000, 8'h1E, 3'd4};

        rst_n = 1'b0; nhsync = 1'b1; clk_2h = 1'b0; flip = 1'b0; nlatch = 1'b1;
        ca = 3'b000; cd = 8'h00; rd = 8'h00; gd = 8'h00; dot_in = 8'h00; pri_in = 3'd0;
        model_clear();
        #2;
        check("reset_state", 8'h00, 3'd0);
        tick(); tick();
        rst_n = 1'b1;

        for (int s = 0; s < 7; s++) run_scen(scen[s], 18, $sformatf("scen%0d", s));

        // Hblank for 3 cycles mid-group with a freshly captured A group in the latch.
        run_scen(scen[0], 13, "hb_pre");
        clk_2h = 1'b0; rd = 8'h03; gd = 8'hF0; flip = 1'b0; dot_in = 8'h20; pri_in = 3'd0;
        tick();
        check("hb_pre_px1", 8'h0E, 3'd5);
        nhsync = 1'b0; rd = 8'h00; gd = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        nhsync = 1'b1;
        for (int i = 0; i < 12; i++) begin
            clk_2h = ((i % 4) >= 2);
            dot_in = 8'h80 + 8'(i);
            tick();
            check($sformatf("hblank_pass%0d", i), dot_in, 3'd0);
        end

        // Reset mid-line while the window holds an opaque group.
        run_scen(scen[0], 13, "rst_pre");
        rd = 8'h00; gd = 8'h00; dot_in = 8'h55; pri_in = 3'd1;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_async", 8'h00, 3'd0);
        rst_n = 1'b1;
        nlatch = 1'b0; ca = 3'b010; cd = 8'h05;
        tick();
        check("rst_release", 8'h55, 3'd1);
        nlatch = 1'b1; ca = 3'b000; pri_in = 3'd0;
        for (int i = 0; i < 12; i++) begin
            clk_2h = ((i % 4) >= 1);
            tick();
            check($sformatf("rst_discard%0d", i), 8'h55, 3'd0);
        end

        // Randomized traffic against the model.
        for (int t = 0; t < 1500; t++) begin
            nhsync = !((t % 53) >= 40 && (t % 53) < 40 + (t % 4) + 1);
            clk_2h = 1'($urandom);
            if ($urandom_range(0, 15) == 0) flip = ~flip;
            nlatch = ($urandom_range(0, 7) != 0);
            ca     = 3'($urandom);
            cd     = 8'($urandom);
            rd     = 8'($urandom);
            gd     = 8'($urandom);
            dot_in = 8'($urandom);
            pri_in = 3'($urandom);
            tick();
            check($sformatf("rand%0d", t), exp_dot, exp_pri);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cus43.md
CUS43 -- requirements
Module: cus43

Interface
REQ-001 SHALL expose parameters, one per line: name, default, meaning:
- DOT_W, 8, colour index width.
- PRI_W, 3, priority width.

REQ-002 SHALL expose ports, one per line: name, direction, width, meaning:
- CLK_6M  in  1  pixel clock; the block's only clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nHSYNC  in  1  low = horizontal blank; clears the group phase.
- CLK_2H  in  1  layer phase from upstream fetch: 0 = layer A byte valid, 1 = layer B byte valid.
- FLIP  in  1  screen flip; reverses pixel order within a group.
- nLATCH  in  1  low = CPU register write strobe, qualified per clock.
- CA  in  3  register address; CA[2] selects the layer (0 = A, 1 = B).
- CD  in  8  CPU write data.
- RD  in  8  tilemap attribute byte for the current phase.
- GD  in  8  tile ROM byte: 4 pixels at 2bpp; GD[7:4] is plane 1, GD[3:0] is plane 0.
- DOT_IN  in  DOT_W  colour from the upstream mixer.
- PRI_IN  in  PRI_W  priority from the upstream mixer.
- DOT_OUT  out  DOT_W  registered mixed colour.
- PRI_OUT  out  PRI_W  registered mixed priority.

Function
REQ-003 SHALL keep a 2-bit group phase px:
- px increments every CLK_6M and wraps 3 to 0.
- px is held at 0 while nHSYNC is low.

REQ-004 SHALL capture RD[5:0] and GD into the layer A holding latch on the edge where CLK_2H=0 and px=1, and into the layer B holding latch where CLK_2H=1 and px=3.

REQ-005 SHALL, on the edge where px goes 3 to 0, shift each layer's 2-group window:
- older group <= newer group.
- newer group <= holding latch.

REQ-006 SHALL decode pixel i (0 = leftmost) of a group as {GD[7-i], GD[3-i]} when FLIP=0, and {GD[4+i], GD[i]} when FLIP=1.

REQ-007 SHALL select the current layer pixel as window index px+fine:
- fine is the layer's 2-bit fine scroll.
- Indices 0-3 address the older group and 4-6 the newer group.
- The colour is {attribute[5:0], pix[1:0]}, using the attribute of the group being addressed.

REQ-008 SHALL treat pix=0 as transparent.

REQ-009 SHALL decode CPU writes on edges with nLATCH=0:
- CA[1:0]=01: fine[CA[2]] <= CD[1:0].
- CA[1:0]=10: pri[CA[2]] <= CD[2:0].
- CA[1:0]=00 and 11: ignored.

REQ-010 SHALL choose a layer candidate each cycle:
- A, if A is opaque and (B is transparent or priA>=priB).
- Otherwise B, if B is opaque.
- Otherwise no candidate.

REQ-011 SHALL register outputs each cycle:
- {DOT_OUT,PRI_OUT} <= candidate colour and priority, if a candidate exists and its priority > PRI_IN.
- Otherwise {DOT_OUT,PRI_OUT} <= {DOT_IN,PRI_IN}. Ties favour upstream.

REQ-012 SHALL have latency:
- DOT_IN to DOT_OUT: exactly 1 cycle.
- A group captured during group n appears at window index 0-3 in group n+2 (fine=0); fine=k advances it by k pixels.

REQ-013 SHALL clear both windows and holding latches to transparent while nHSYNC is low, so the first two groups of each line output upstream data.

REQ-014 SHALL apply a CPU write in the same cycle as a pixel read so that the new fine or pri value takes effect on the next edge; the current pixel uses the old value.

REQ-015 SHALL sample FLIP at capture time (REQ-004); a FLIP change mid-line affects only groups captured afterwards.

Reset
REQ-016 SHALL, while rst_n=0, asynchronously clear all state: px, latches, windows, fine, pri, DOT_OUT and PRI_OUT all 0.

REQ-017 SHALL resume with px=0 on the first edge after rst_n rises; reset asserted mid-line discards all in-flight groups.

Configuration
REQ-018 SHALL honour macro CUS43_FINE_SCROLL_EN:
- Defined: fine registers and REQ-009 CA[1:0]=01 writes operate.
- Undefined: fine is constant 0, those writes are ignored, and the index is px.

Structure
REQ-019 SHALL place the following in shared package system86_pkg:
- DOT_W and PRI_W defaults.
- Register offset constants REG_FINE=2'b01 and REG_PRI=2'b10.
- A layer-select enum (LAYER_A=0, LAYER_B=1).

REQ-020 SHALL instantiate sub-module cus43_layer twice (A and B). Each instance contains:
- holding latch, window, fine and pri registers.
- pixel decode.
- outputs: pixel colour, opaque flag, priority.

The top level holds px, write decode, the mixer and the output registers.

Verification
REQ-021 SHALL cover reset: assert rst_n=0 mid-line with DOT_IN=8'h55 -> DOT_OUT=0 and PRI_OUT=0 immediately; DOT_OUT=8'h55 one cycle after release.

REQ-022 SHALL cover layer A display: pri A=5, fine=0, PRI_IN=2, RD=8'h03, GD=8'hF0 captured in group n -> DOT_OUT=8'h0E for the 4 pixels of group n+2, delayed 1 cycle.

REQ-023 SHALL cover fine scroll: same data with fine=2 -> 8'h0E begins 2 pixels earlier; with CUS43_FINE_SCROLL_EN undefined the timing is unchanged from fine=0.

REQ-024 SHALL cover FLIP: GD=8'h80, FLIP=0 -> pix=2 at pixel 0 only; FLIP=1 -> pix=2 at pixel 3 only.

REQ-025 SHALL cover priority ties:
- priA=priB=4, both opaque -> layer A colour.
- PRI_IN=4 -> DOT_IN passes through.
- PRI_IN=3 -> layer A colour.

REQ-026 SHALL cover hblank: nHSYNC low for 3 cycles in the middle of a group -> windows cleared, px=0 after release, DOT_OUT=DOT_IN for the next 8 pixels.
